ins_dispatch: RTL



---
 rtl/dispatch_pkg.sv | 26 ++
 rtl/dispatch_fifo.sv | 60 ++++++
 rtl/ins_dispatch.sv | 72 +++++++
 3 files changed

// File: rtl/dispatch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dispatch_pkg
//  Brief    : Shared widths, defaults and the broadcast-bit position.
//  Revision : 1.0
// ============================================================================
package dispatch_pkg;

    localparam int DEF_INS_W  = 16;
    localparam int DEF_PAY_W  = 12;
    localparam int DEF_NUM_CH = 4;
    localparam int DEF_DEPTH  = 2;

    // Broadcast flag sits this many bits below INS_W (i.e. the MSB).
    localparam int BCAST_MSB_OFFSET = 1;

    function automatic int sel_width(input int num_ch);
        return $clog2(num_ch);
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dispatch_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : dispatch_fifo
//  Brief    : Single-clock FIFO with occupancy count and zero-when-empty head.
//  Revision : 1.0
// ============================================================================
module dispatch_fifo
    import dispatch_pkg::*;
#(
    parameter int PAY_W = DEF_PAY_W,
    parameter int DEPTH = DEF_DEPTH,
    localparam int CNT_W = cnt_width(DEPTH),
    localparam int PTR_W = CNT_W - 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [PAY_W-1:0] wr_data,
    output logic [PAY_W-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             not_empty
);

    logic [PAY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == CNT_W'(DEPTH));
    assign not_empty = (count != '0);
    // A full FIFO refuses pushes even when it is popped in the same cycle.
    assign do_push   = push && !full;
    assign do_pop    = pop && not_empty;
    assign head      = not_empty ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule
`default_nettype wire

// File: rtl/ins_dispatch.sv
`default_nettype none
// ============================================================================
//  Module   : ins_dispatch
//  Brief    : Decodes a channel select and queues payloads into per-channel
//             FIFOs. Define BROADCAST_EN to enable MSB-flagged broadcast.
//  Revision : 1.0
// ============================================================================
module ins_dispatch
    import dispatch_pkg::*;
#(
    parameter int INS_W  = DEF_INS_W,
    parameter int PAY_W  = DEF_PAY_W,
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int DEPTH  = DEF_DEPTH,
    localparam int SEL_W = sel_width(NUM_CH),
    localparam int CNT_W = cnt_width(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [INS_W-1:0]        in_ins,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [NUM_CH*PAY_W-1:0] out_data,
    output logic [NUM_CH-1:0]       out_valid,
    input  logic [NUM_CH-1:0]       out_ready,
    output logic [NUM_CH*CNT_W-1:0] fill
);

    logic [SEL_W-1:0]  sel;
    logic [NUM_CH-1:0] full;
    logic              accept;
    logic              is_bcast;
    logic              unused_ins;

    assign sel        = in_ins[PAY_W +: SEL_W];
    assign unused_ins = ^in_ins;

`ifdef BROADCAST_EN
    assign is_bcast = in_ins[INS_W-BCAST_MSB_OFFSET];
    assign in_ready = is_bcast ? ~|full : ~full[sel];
`else
    assign is_bcast = 1'b0;
    assign in_ready = ~full[sel];
`endif

    assign accept = in_valid && in_ready;

    genvar c;
    generate
        for (c = 0; c < NUM_CH; c++) begin : g_ch
            logic push;
            assign push = accept && (is_bcast || (sel == SEL_W'(c)));

            dispatch_fifo #(
                .PAY_W (PAY_W),
                .DEPTH (DEPTH)
            ) u_fifo (
                .clk       (clk),
                .rst_n     (rst_n),
                .push      (push),
                .pop       (out_ready[c]),
                .wr_data   (in_ins[PAY_W-1:0]),
                .head      (out_data[c*PAY_W +: PAY_W]),
                .count     (fill[c*CNT_W +: CNT_W]),
                .full      (full[c]),
                .not_empty (out_valid[c])
            );
        end
    endgenerate

endmodule
`default_nettype wire
